serial_adder: RTL and testbench

Parametrised bit-serial adder/subtractor. It is built around a single one-bit full-adder cell and a registered carry. Two WIDTH-bit operands are loaded on a start pulse and processed LSB-first, one bit per clock. The block reports sum, carry-out and signed overflow with a done pulse. It is the sequential, width-generic successor to the combinational one-bit full adder, and is intended for area-constrained datapaths and teaching examples.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/fa_cell.sv | 15 +
 rtl/serial_adder.sv | 120 ++++++++++++
 tb/tb_serial_adder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding, operation
// modes and the majority function used by the full-adder cell.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic element of the serial datapath.
module fa_cell
   import serial_adder_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = maj3(x, y, ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor: operands are consumed LSB-first, one bit per
// clock, through a single full-adder cell with a registered carry.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter  int unsigned WIDTH = 8,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic               carry_q, carry_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   // Holds the WIDTH-1 lower result bits; the final bit joins them on the last edge.
   logic [WIDTH-2:0]   res_q, res_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic               fa_s;
   logic               fa_co;
   logic [WIDTH-1:0]   res_full;
   logic               last_bit;

   fa_cell u_fa_cell (
      .x  (op_a_q[0]),
      .y  (op_b_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   assign res_full = {fa_s, res_q};
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

   always_comb begin
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               op_a_d  = a;
               op_b_d  = (sub == MODE_ADD) ? b : ~b;
               carry_d = (sub == MODE_SUB);
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            carry_d = fa_co;
            res_d   = res_full[WIDTH-1:1];
            op_a_d  = op_a_q >> 1;
            op_b_d  = op_b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
               // carry_q here is the carry into the MSB.
               sum_d   = res_full;
               cout_d  = fa_co;
               ovf_d   = carry_q ^ fa_co;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q == ST_SHIFT);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH 2/4/8/16: directed vectors plus an arithmetic
// reference model compared against every instance on every cycle.
module tb_serial_adder;

   localparam int NI = 4;

   typedef struct packed {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b1;
   logic [NI-1:0]     start_v = '0;
   logic [NI-1:0]     sub_v   = '0;
   logic [15:0]       a_v [NI] = '{default: '0};
   logic [15:0]       b_v [NI] = '{default: '0};

   wire  [NI-1:0]     busy_v;
   wire  [NI-1:0]     done_v;
   wire  [NI-1:0]     cout_v;
   wire  [NI-1:0]     ovf_v;
   wire  [1:0]        sum2;
   wire  [3:0]        sum4;
   wire  [7:0]        sum8;
   wire  [15:0]       sum16;
   wire  [15:0]       sum_v [NI];

   int                total = 0;
   int                bad   = 0;

   int                ph    [NI] = '{default: 0};
   res_t              pend  [NI] = '{default: '0};
   res_t              exp_r [NI] = '{default: '0};

   always #5 clk = ~clk;

   assign sum_v[0] = {14'd0, sum2};
   assign sum_v[1] = {12'd0, sum4};
   assign sum_v[2] = {8'd0, sum8};
   assign sum_v[3] = sum16;

   serial_adder #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
      .a(a_v[0][1:0]), .b(b_v[0][1:0]), .busy(busy_v[0]), .done(done_v[0]),
      .sum(sum2), .cout(cout_v[0]), .ovf(ovf_v[0])
   );
   serial_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
      .a(a_v[1][3:0]), .b(b_v[1][3:0]), .busy(busy_v[1]), .done(done_v[1]),
      .sum(sum4), .cout(cout_v[1]), .ovf(ovf_v[1])
   );
   serial_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
      .a(a_v[2][7:0]), .b(b_v[2][7:0]), .busy(busy_v[2]), .done(done_v[2]),
      .sum(sum8), .cout(cout_v[2]), .ovf(ovf_v[2])
   );
   serial_adder #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[3]), .sub(sub_v[3]),
      .a(a_v[3]), .b(b_v[3]), .busy(busy_v[3]), .done(done_v[3]),
      .sum(sum16), .cout(cout_v[3]), .ovf(ovf_v[3])
   );

   function automatic int wid(input int i);
      return (i == 0) ? 2 : (i == 1) ? 4 : (i == 2) ? 8 : 16;
   endfunction

   // Plain modular arithmetic; overflow from the operand/result sign rule.
   function automatic res_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                  input logic sub);
      logic [16:0] mask;
      logic [16:0] tot;
      logic [15:0] am, bm, bx, s;
      res_t        r;
      mask = (17'd1 << w) - 17'd1;
      am   = a & mask[15:0];
      bm   = b & mask[15:0];
      bx   = sub ? (~bm & mask[15:0]) : bm;
      tot  = {1'b0, am} + {1'b0, bx} + {16'd0, sub};
      s    = tot[15:0] & mask[15:0];
      r.sum  = s;
      r.cout = tot[w];
      if (sub) r.ovf = (am[w-1] != bm[w-1]) && (s[w-1] != am[w-1]);
      else     r.ovf = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference schedule: phase 1..W busy, W+1 done, results published entering done.
   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            ph[i]    <= 0;
            exp_r[i] <= '0;
         end else if (ph[i] == 0 || ph[i] == wid(i) + 1) begin
            if (start_v[i]) begin
               pend[i] <= model(wid(i), a_v[i], b_v[i], sub_v[i]);
               ph[i]   <= 1;
            end else begin
               ph[i] <= 0;
            end
         end else begin
            ph[i] <= ph[i] + 1;
            if (ph[i] == wid(i)) exp_r[i] <= pend[i];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         check($sformatf("busy_w%0d", wid(i)), 32'(busy_v[i]),
               32'(ph[i] >= 1 && ph[i] <= wid(i)));
         check($sformatf("done_w%0d", wid(i)), 32'(done_v[i]), 32'(ph[i] == wid(i) + 1));
         check($sformatf("sum_w%0d", wid(i)), 32'(sum_v[i]), 32'(exp_r[i].sum));
         check($sformatf("cout_w%0d", wid(i)), 32'(cout_v[i]), 32'(exp_r[i].cout));
         check($sformatf("ovf_w%0d", wid(i)), 32'(ovf_v[i]), 32'(exp_r[i].ovf));
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic sub);
      start_v[i] = 1'b1;
      a_v[i]     = a;
      b_v[i]     = b;
      sub_v[i]   = sub;
      @(posedge clk);
      #1 start_v[i] = 1'b0;
   endtask

   task automatic await_done(input int i, input int c0, input int ecyc, input logic [15:0] es,
                             input logic ec, input logic eo, input string nm);
      int c;
      c = c0;
      do begin
         @(negedge clk);
         c++;
      end while (!done_v[i] && c < c0 + 60);
      check({nm, "_cycle"}, 32'(c), 32'(ecyc));
      check({nm, "_sum"}, 32'(sum_v[i]), 32'(es));
      check({nm, "_cout"}, 32'(cout_v[i]), 32'(ec));
      check({nm, "_ovf"}, 32'(ovf_v[i]), 32'(eo));
   endtask

   initial begin
      int   c;
      int   nd;
      res_t r;

      // Pin the reference model with hand-worked results.
      r = model(8, 16'h5A, 16'h3C, 1'b0);
      check("pin_add8", 32'(r), 32'({16'h0096, 1'b0, 1'b1}));
      r = model(2, 16'h2, 16'h1, 1'b1);
      check("pin_sub2", 32'(r), 32'({16'h0001, 1'b1, 1'b1}));
      r = model(16, 16'h8000, 16'h8000, 1'b0);
      check("pin_add16", 32'(r), 32'({16'h0000, 1'b1, 1'b1}));

      #1 rst_n = 1'b0;
      #2;
      check("rst_busy", 32'(busy_v[2]), 32'd0);
      check("rst_done", 32'(done_v[2]), 32'd0);
      check("rst_sum", 32'(sum8), 32'd0);
      check("rst_cout", 32'(cout_v[2]), 32'd0);
      check("rst_ovf", 32'(ovf_v[2]), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      launch(2, 16'h5A, 16'h3C, 1'b0);
      await_done(2, 0, 9, 16'h96, 1'b0, 1'b1, "add_ovf");
      idle(2);
      launch(2, 16'h10, 16'h20, 1'b1);
      await_done(2, 0, 9, 16'hF0, 1'b0, 1'b0, "sub_borrow");
      idle(2);
      launch(2, 16'h80, 16'h01, 1'b1);
      await_done(2, 0, 9, 16'h7F, 1'b1, 1'b1, "sub_ovf");
      idle(2);
      launch(2, 16'hFF, 16'h01, 1'b0);
      await_done(2, 0, 9, 16'h00, 1'b1, 1'b0, "wrap");
      idle(2);

      // Start pulsed mid-operation must be ignored.
      launch(2, 16'h5A, 16'h3C, 1'b0);
      c = 0;
      while (c < 60 && !done_v[2]) begin
         @(negedge clk);
         c++;
         if (c == 4) begin
            start_v[2] = 1'b1;
            a_v[2]     = 16'h11;
            b_v[2]     = 16'h22;
         end else if (c == 5) begin
            start_v[2] = 1'b0;
         end
      end
      check("ign_cycle", 32'(c), 32'd9);
      check("ign_sum", 32'(sum8), 32'h96);

      // Back-to-back: start held during the DONE cycle.
      start_v[2] = 1'b1;
      a_v[2]     = 16'h01;
      b_v[2]     = 16'h02;
      sub_v[2]   = 1'b0;
      @(posedge clk);
      #1 start_v[2] = 1'b0;
      @(negedge clk);
      check("b2b_busy", 32'(busy_v[2]), 32'd1);
      await_done(2, 1, 9, 16'h03, 1'b0, 1'b0, "b2b");
      idle(2);

      // Asynchronous reset in the middle of an operation.
      launch(2, 16'h33, 16'h44, 1'b0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_v[2]), 32'd0);
      check("mid_rst_done", 32'(done_v[2]), 32'd0);
      check("mid_rst_sum", 32'(sum8), 32'd0);
      check("mid_rst_cout", 32'(cout_v[2]), 32'd0);
      check("mid_rst_ovf", 32'(ovf_v[2]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_v[2]) nd++;
      end
      check("mid_rst_no_done", 32'(nd), 32'd0);
      launch(2, 16'h05, 16'h03, 1'b0);
      await_done(2, 0, 9, 16'h08, 1'b0, 1'b0, "post_rst");
      idle(2);

      launch(1, 16'h7, 16'h1, 1'b0);
      await_done(1, 0, 5, 16'h8, 1'b0, 1'b1, "w4_add");
      idle(2);

      // Random operands on the 2-, 8- and 16-bit instances together.
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < NI; i++) begin
            if (i != 1) begin
               start_v[i] = 1'b1;
               a_v[i]     = 16'($urandom);
               b_v[i]     = 16'($urandom);
               sub_v[i]   = 1'($urandom_range(0, 1));
            end
         end
         r = model(16, a_v[3], b_v[3], sub_v[3]);
         @(posedge clk);
         #1 start_v = '0;
         await_done(3, 0, 17, r.sum, r.cout, r.ovf, "rnd16");
         idle(1);
      end

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
